rvfi_monitor: RTL

Passive consumer of the dtcore32 RVFI retirement stream; sits beside the core in formal/sim wrappers and in FPGA debug builds.
- Checks architectural consistency of each retired instruction: order sequence, PC continuity, x0 writes, memory-mask legality, post-halt retirement and, optionally, source-register values against a shadow register file.
- Flags the first violation with a sticky error and captures its context.

---
 rtl/rvfi_mon_pkg.sv | 49 ++++
 rtl/rvfi_mon_shadow_rf.sv | 65 ++++++
 rtl/rvfi_monitor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rvfi_mon_pkg.sv
// Shared types and helpers for the RVFI retirement monitor.
package rvfi_mon_pkg;

  typedef enum logic [3:0] {
    ERR_NONE        = 4'd0,
    ERR_ORDER       = 4'd1,
    ERR_PC          = 4'd2,
    ERR_X0          = 4'd3,
    ERR_MEM_BOTH    = 4'd4,
    ERR_MEM_MASK    = 4'd5,
    ERR_RS_MISMATCH = 4'd6,
    ERR_HALT_RETIRE = 4'd7
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED,
    ST_FAIL
  } state_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B0   = 4'b0001;
  localparam logic [3:0] MASK_B1   = 4'b0010;
  localparam logic [3:0] MASK_B2   = 4'b0100;
  localparam logic [3:0] MASK_B3   = 4'b1000;
  localparam logic [3:0] MASK_H0   = 4'b0011;
  localparam logic [3:0] MASK_H1   = 4'b1100;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // A byte mask is legal if it is one of the naturally aligned shapes and
  // sits where the low address bits say it should. An empty mask is legal.
  function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] addr);
    logic ok;
    case (mask)
      MASK_NONE: ok = 1'b1;
      MASK_B0:   ok = (addr == 2'd0);
      MASK_B1:   ok = (addr == 2'd1);
      MASK_B2:   ok = (addr == 2'd2);
      MASK_B3:   ok = (addr == 2'd3);
      MASK_H0:   ok = (addr[1] == 1'b0);
      MASK_H1:   ok = (addr[1] == 1'b1);
      MASK_W:    ok = (addr == 2'd0);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rvfi_mon_shadow_rf.sv
// Shadow integer register file used to cross-check retired source operands.
// Writes land on the clock edge after the writing retirement, so the very
// next retirement already reads the new value from the array.
module rvfi_mon_shadow_rf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [31:0] rs1_rdata_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [31:0] rs2_rdata_i,
  output logic        rs1_bad_o,
  output logic        rs2_bad_o
);

  logic [31:0] regs_q [32];
  logic [31:0] valid_q;
  logic [31:0] valid_d;

  // Valid bits: set on write, wiped by clear.
  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[waddr_i] = 1'b1;
    end
  end

  // Valid-bit register with async reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data storage needs no reset; entries are only trusted once valid.
  always_ff @(posedge clk_i) begin
    if (we_i && !clear_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Operand compare: x0 must read zero, other registers must match once known.
  always_comb begin
    rs1_bad_o = 1'b0;
    rs2_bad_o = 1'b0;
    if (rs1_addr_i == '0) begin
      rs1_bad_o = (rs1_rdata_i != '0);
    end else if (valid_q[rs1_addr_i]) begin
      rs1_bad_o = (rs1_rdata_i != regs_q[rs1_addr_i]);
    end
    if (rs2_addr_i == '0) begin
      rs2_bad_o = (rs2_rdata_i != '0);
    end else if (valid_q[rs2_addr_i]) begin
      rs2_bad_o = (rs2_rdata_i != regs_q[rs2_addr_i]);
    end
  end

endmodule

// File: rtl/rvfi_monitor.sv
// Passive RVFI retirement checker: order, PC continuity, x0 writes, memory
// mask legality and post-halt retirement; first error is sticky and captured.
// Optional shadow register-file operand check enabled by RVFI_MON_SHADOW_EN.
module rvfi_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int unsigned ORDER_W  = 64,
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               rvfi_valid,
  input  logic [ORDER_W-1:0] rvfi_order,
  input  logic [31:0]        rvfi_insn,
  input  logic               rvfi_trap,
  input  logic               rvfi_halt,
  input  logic               rvfi_intr,
  input  logic [4:0]         rvfi_rs1_addr,
  input  logic [4:0]         rvfi_rs2_addr,
  input  logic [31:0]        rvfi_rs1_rdata,
  input  logic [31:0]        rvfi_rs2_rdata,
  input  logic [4:0]         rvfi_rd_addr,
  input  logic [31:0]        rvfi_rd_wdata,
  input  logic [31:0]        rvfi_pc_rdata,
  input  logic [31:0]        rvfi_pc_wdata,
  input  logic [31:0]        rvfi_mem_addr,
  input  logic [3:0]         rvfi_mem_rmask,
  input  logic [3:0]         rvfi_mem_wmask,
  output logic               err_o,
  output logic [3:0]         err_code_o,
  output logic [ORDER_W-1:0] err_order_o,
  output logic [31:0]        err_pc_o,
  output logic [CNT_W-1:0]   retired_cnt_o,
  output logic               halted_o
);

  state_e             state_q, state_d;
  logic [ORDER_W-1:0] exp_order_q, exp_order_d;
  logic [31:0]        exp_pc_q, exp_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  err_code_e          err_code_q, err_code_d;
  logic [ORDER_W-1:0] err_order_q, err_order_d;
  logic [31:0]        err_pc_q, err_pc_d;
  logic               halted_q, halted_d;

  err_code_e code_sel;
  logic      rs_bad;
  logic      chk_active;
  logic      err_hit;
  logic      accept;

  logic unused_sink;
  assign unused_sink = ^{rvfi_insn, rvfi_mem_addr[31:2]};

`ifdef RVFI_MON_SHADOW_EN
  logic rs1_bad, rs2_bad, sh_we;
  assign sh_we  = accept && !rvfi_trap && (rvfi_rd_addr != '0);
  assign rs_bad = rs1_bad | rs2_bad;

  rvfi_mon_shadow_rf u_shadow (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .we_i        (sh_we),
    .waddr_i     (rvfi_rd_addr),
    .wdata_i     (rvfi_rd_wdata),
    .rs1_addr_i  (rvfi_rs1_addr),
    .rs1_rdata_i (rvfi_rs1_rdata),
    .rs2_addr_i  (rvfi_rs2_addr),
    .rs2_rdata_i (rvfi_rs2_rdata),
    .rs1_bad_o   (rs1_bad),
    .rs2_bad_o   (rs2_bad)
  );
`else
  logic unused_shadow_sink;
  assign unused_shadow_sink = ^{rvfi_trap, rvfi_rs1_addr, rvfi_rs2_addr,
                                rvfi_rs1_rdata, rvfi_rs2_rdata};
  assign rs_bad = 1'b0;
`endif

  // Highest-priority violation of the current retirement.
  always_comb begin
    code_sel = ERR_NONE;
    if (rvfi_order != exp_order_q) begin
      code_sel = ERR_ORDER;
    end else if ((rvfi_pc_rdata != exp_pc_q) && !rvfi_intr) begin
      code_sel = ERR_PC;
    end else if ((rvfi_rd_addr == '0) && (rvfi_rd_wdata != '0)) begin
      code_sel = ERR_X0;
    end else if ((rvfi_mem_rmask != '0) && (rvfi_mem_wmask != '0)) begin
      code_sel = ERR_MEM_BOTH;
    end else if (!mask_legal(rvfi_mem_rmask, rvfi_mem_addr[1:0]) ||
                 !mask_legal(rvfi_mem_wmask, rvfi_mem_addr[1:0])) begin
      code_sel = ERR_MEM_MASK;
    end else if (rs_bad) begin
      code_sel = ERR_RS_MISMATCH;
    end else if (state_q == ST_HALTED) begin
      code_sel = ERR_HALT_RETIRE;
    end
  end

  // Next-state: clear first, then a new error overrides (error beats clear),
  // otherwise an accepted retirement advances the expectations.
  always_comb begin
    chk_active  = rvfi_valid && ((state_q != ST_FAIL) || clear_i);
    err_hit     = chk_active && (code_sel != ERR_NONE);
    accept      = rvfi_valid && !err_hit && (state_q != ST_FAIL) && !clear_i;

    state_d     = state_q;
    exp_order_d = exp_order_q;
    exp_pc_d    = exp_pc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_order_d = err_order_q;
    err_pc_d    = err_pc_q;
    halted_d    = halted_q;

    if (clear_i) begin
      state_d     = ST_IDLE;
      exp_order_d = '0;
      exp_pc_d    = RESET_PC;
      cnt_d       = '0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
      err_order_d = '0;
      err_pc_d    = '0;
      halted_d    = 1'b0;
    end

    if (err_hit) begin
      state_d     = ST_FAIL;
      err_d       = 1'b1;
      err_code_d  = code_sel;
      err_order_d = rvfi_order;
      err_pc_d    = rvfi_pc_rdata;
    end else if (accept) begin
      exp_order_d = exp_order_q + ORDER_W'(1);
      exp_pc_d    = rvfi_pc_wdata;
      cnt_d       = cnt_q + CNT_W'(1);
      if (rvfi_halt) begin
        state_d  = ST_HALTED;
        halted_d = 1'b1;
      end else begin
        state_d  = ST_RUN;
      end
    end
  end

  // Monitor state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      exp_order_q <= '0;
      exp_pc_q    <= RESET_PC;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_order_q <= '0;
      err_pc_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_order_q <= exp_order_d;
      exp_pc_q    <= exp_pc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_order_q <= err_order_d;
      err_pc_q    <= err_pc_d;
      halted_q    <= halted_d;
    end
  end

  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign err_order_o   = err_order_q;
  assign err_pc_o      = err_pc_q;
  assign retired_cnt_o = cnt_q;
  assign halted_o      = halted_q;

endmodule
